// File: rtl/mem_port_arbiter.sv
// Shares the single-port data memory between the CPU load/store path and the I/O port.
// One owner per cycle, same-cycle grant, read data routed back to its owner one cycle later.
module mem_port_arbiter #(
  parameter int WIDTH        = 36,
  parameter int MEMADDRWIDTH = 16,
  parameter int MAXBURST     = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    startIO,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [MEMADDRWIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0]        cpu_wdata,
  output logic                    cpu_gnt,
  output logic                    cpu_rvalid,
  output logic [WIDTH-1:0]        cpu_rdata,
  output logic                    cpu_stall,
  input  logic                    io_req,
  input  logic                    io_we,
  input  logic [MEMADDRWIDTH-1:0] io_addr,
  input  logic [WIDTH-1:0]        io_wdata,
  output logic                    io_gnt,
  output logic                    io_rvalid,
  output logic [WIDTH-1:0]        io_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [MEMADDRWIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]        mem_wdata,
  input  logic [WIDTH-1:0]        mem_rdata
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] BURST_MAX = 4'(MAXBURST);

  logic       sync1_r;
  logic       run_r;
  state_t     state_r;
  state_t     mode_s;
  logic [3:0] burst_cnt_r;
  logic [3:0] burst_cnt_s;
  logic       burst_at_max_s;
  logic       cpu_win_s;
  logic       io_win_s;
  logic       rd_pending_r;
  logic       rd_owner_r;
  logic [WIDTH-1:0] cpu_hold_r;
  logic [WIDTH-1:0] io_hold_r;

  // Two-flop synchronizer bringing startIO into the clock domain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b0;
      run_r   <= 1'b0;
    end else begin
      sync1_r <= startIO;
      run_r   <= sync1_r;
    end
  end

  // State register; it stores the mode that was in force during the cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_HALT;
    end else begin
      state_r <= mode_s;
    end
  end

  // Current mode follows run without an extra cycle of delay, so arbitration
  // starts the cycle run rises and DRAIN covers the cycle run falls.
  always_comb begin
    mode_s = ST_HALT;
    case (state_r)
      ST_HALT:  mode_s = run_r ? ST_RUN : ST_HALT;
      ST_RUN:   mode_s = run_r ? ST_RUN : ST_DRAIN;
      ST_DRAIN: mode_s = ST_HALT;
      default:  mode_s = ST_HALT;
    endcase
  end

  assign burst_at_max_s = (burst_cnt_r == BURST_MAX);

  // Winner selection; reset forces both grants low so nothing reaches memory.
  always_comb begin
    cpu_win_s = 1'b0;
    io_win_s  = 1'b0;
    if (reset) begin
      cpu_win_s = 1'b0;
      io_win_s  = 1'b0;
    end else begin
      case (mode_s)
        ST_RUN: begin
          if (cpu_req && io_req) begin
            if (burst_at_max_s) begin
              io_win_s = 1'b1;
            end else begin
              cpu_win_s = 1'b1;
            end
          end else if (cpu_req) begin
            cpu_win_s = 1'b1;
          end else if (io_req) begin
            io_win_s = 1'b1;
          end else begin
            cpu_win_s = 1'b0;
            io_win_s  = 1'b0;
          end
        end
        ST_HALT, ST_DRAIN: io_win_s = io_req;
        default: begin
          cpu_win_s = 1'b0;
          io_win_s  = 1'b0;
        end
      endcase
    end
  end

  // Counts CPU grants taken while I/O waits; any I/O grant or idle I/O clears it.
  always_comb begin
    burst_cnt_s = burst_cnt_r;
    if (mode_s != ST_RUN || !io_req || io_win_s) begin
      burst_cnt_s = 4'd0;
    end else if (cpu_win_s && !burst_at_max_s) begin
      burst_cnt_s = burst_cnt_r + 4'd1;
    end else begin
      burst_cnt_s = burst_cnt_r;
    end
  end

  // Burst counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      burst_cnt_r <= 4'd0;
    end else begin
      burst_cnt_r <= burst_cnt_s;
    end
  end

  // Memory port mux from the winning requester.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = {MEMADDRWIDTH{1'b0}};
    mem_wdata = {WIDTH{1'b0}};
    if (cpu_win_s) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (io_win_s) begin
      mem_we    = io_we;
      mem_addr  = io_addr;
      mem_wdata = io_wdata;
    end else begin
      mem_we    = 1'b0;
      mem_addr  = {MEMADDRWIDTH{1'b0}};
      mem_wdata = {WIDTH{1'b0}};
    end
  end

  assign mem_en = cpu_win_s | io_win_s;

  // Read tag: which port owns the data arriving from memory next cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_pending_r <= 1'b0;
      rd_owner_r   <= 1'b0;
    end else begin
      rd_pending_r <= mem_en & ~mem_we;
      rd_owner_r   <= io_win_s;
    end
  end

  assign cpu_rvalid = rd_pending_r & ~rd_owner_r;
  assign io_rvalid  = rd_pending_r &  rd_owner_r;

  // Last delivered word per port, so a port's rdata is stable between returns.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_hold_r <= {WIDTH{1'b0}};
      io_hold_r  <= {WIDTH{1'b0}};
    end else begin
      if (cpu_rvalid) begin
        cpu_hold_r <= mem_rdata;
      end
      if (io_rvalid) begin
        io_hold_r <= mem_rdata;
      end
    end
  end

  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_hold_r;
  assign io_rdata  = io_rvalid  ? mem_rdata : io_hold_r;
  assign cpu_gnt   = cpu_win_s;
  assign io_gnt    = io_win_s;
  assign cpu_stall = (mode_s == ST_RUN) ? (cpu_req & ~cpu_win_s) : 1'b1;

  mem_port_arbiter_chk u_chk (
    .clock      (clock),
    .reset      (reset),
    .cpu_gnt    (cpu_gnt),
    .io_gnt     (io_gnt),
    .mem_en     (mem_en),
    .cpu_rvalid (cpu_rvalid),
    .io_rvalid  (io_rvalid)
  );

endmodule

// Protocol invariants of the arbiter: exclusive ownership and consistent enables.
module mem_port_arbiter_chk (
  input logic clock,
  input logic reset,
  input logic cpu_gnt,
  input logic io_gnt,
  input logic mem_en,
  input logic cpu_rvalid,
  input logic io_rvalid
);

  a_one_grant: assert property (@(posedge clock) disable iff (reset) !(cpu_gnt && io_gnt));
  a_en_match:  assert property (@(posedge clock) disable iff (reset) mem_en == (cpu_gnt | io_gnt));
  a_one_rv:    assert property (@(posedge clock) disable iff (reset) !(cpu_rvalid && io_rvalid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grants checked inline, read returns
// checked by a negedge monitor against a queue of expected responses.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        startIO;
  logic        cpu_req, cpu_we, io_req, io_we;
  logic [15:0] cpu_addr, io_addr, mem_addr;
  logic [35:0] cpu_wdata, io_wdata, mem_wdata, mem_rdata;
  logic        cpu_gnt, cpu_rvalid, cpu_stall, io_gnt, io_rvalid, mem_en, mem_we;
  logic [35:0] cpu_rdata, io_rdata;

  typedef struct {
    bit          port;
    logic [35:0] data;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [35:0] tmem [0:255];
  logic [35:0] last_c, last_i;

  mem_port_arbiter #(.WIDTH(36), .MEMADDRWIDTH(16), .MAXBURST(4)) dut (
    .clock(clock), .reset(reset), .startIO(startIO),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous single-port memory model.
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) tmem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= tmem[mem_addr[7:0]];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input bit port, input logic [35:0] d);
    exp_t e;
    e.port = port;
    e.data = d;
    e.cyc  = cyc + 1;
    q.push_back(e);
  endtask

  task automatic step(input bit si,
                      input bit cr, input bit cw, input logic [15:0] ca, input logic [35:0] cd,
                      input bit ir, input bit iw, input logic [15:0] ia, input logic [35:0] id);
    @(negedge clock);
    startIO = si;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    io_req  = ir; io_we  = iw; io_addr  = ia; io_wdata  = id;
    #1;
  endtask

  // Monitor: pops expected read returns and checks rdata holding between returns.
  always @(negedge clock) begin
    if (reset) begin
      last_c = 36'd0;
      last_i = 36'd0;
    end else begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("rv_missing", 64'(q[0].cyc), 64'(cyc));
        void'(q.pop_front());
      end
      if (cpu_rvalid || io_rvalid) begin
        chk("rv_both", 64'(cpu_rvalid & io_rvalid), 64'd0);
        if (q.size() == 0) begin
          chk("rv_unexpected", {62'd0, cpu_rvalid, io_rvalid}, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rv_port", {62'd0, cpu_rvalid, io_rvalid}, e.port ? 64'd1 : 64'd2);
          chk("rv_data", 64'(e.port ? io_rdata : cpu_rdata), 64'(e.data));
          chk("rv_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (!cpu_rvalid) chk("cpu_rdata_hold", 64'(cpu_rdata), 64'(last_c));
      else last_c = cpu_rdata;
      if (!io_rvalid) chk("io_rdata_hold", 64'(io_rdata), 64'(last_i));
      else last_i = io_rdata;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_io;
    for (int i = 0; i < 256; i++) tmem[i] = 36'd0;
    mem_rdata = 36'd0;
    reset = 1'b1; startIO = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'd9; cpu_wdata = 36'h5;
    io_req = 1'b1; io_we = 1'b1; io_addr = 16'd7; io_wdata = 36'h77;
    #3;
    chk("rst_cpu_gnt", 64'(cpu_gnt), 64'd0);
    chk("rst_io_gnt", 64'(io_gnt), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_rvalid", {62'd0, cpu_rvalid, io_rvalid}, 64'd0);
    chk("rst_rdata", {28'd0, cpu_rdata} | {28'd0, io_rdata}, 64'd0);
    chk("rst_stall", 64'(cpu_stall), 64'd1);
    repeat (2) @(negedge clock);
    cpu_req = 1'b0; io_req = 1'b0;
    reset = 1'b0;

    // HALT: CPU held off, I/O served.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'd5, 36'd0, 1'b0, 1'b0, 16'd0, 36'd0);
      chk("halt_cpu_gnt", 64'(cpu_gnt), 64'd0);
      chk("halt_cpu_stall", 64'(cpu_stall), 64'd1);
    end
    step(1'b0, 1'b1, 1'b0, 16'd5, 36'd0, 1'b1, 1'b1, 16'd5, 36'h123456789);
    chk("halt_io_gnt", 64'(io_gnt), 64'd1);
    chk("halt_cpu_gnt2", 64'(cpu_gnt), 64'd0);
    chk("halt_mem_we", 64'(mem_we), 64'd1);
    chk("halt_mem_addr", 64'(mem_addr), 64'd5);
    chk("halt_mem_wdata", 64'(mem_wdata), 64'h123456789);
    step(1'b0, 1'b1, 1'b0, 16'd5, 36'd0, 1'b1, 1'b1, 16'd1, 36'hA);
    chk("halt_io_gnt_a", 64'(io_gnt), 64'd1);
    step(1'b0, 1'b1, 1'b0, 16'd5, 36'd0, 1'b1, 1'b1, 16'd2, 36'hB);
    chk("halt_io_gnt_b", 64'(io_gnt), 64'd1);

    // Run entry: first CPU grant is sampled on the 3rd edge after startIO rises.
    step(1'b1, 1'b1, 1'b0, 16'd5, 36'd0, 1'b0, 1'b0, 16'd0, 36'd0);
    chk("entry_gnt_e1", 64'(cpu_gnt), 64'd0);
    step(1'b1, 1'b1, 1'b0, 16'd5, 36'd0, 1'b0, 1'b0, 16'd0, 36'd0);
    chk("entry_gnt_e2", 64'(cpu_gnt), 64'd0);
    step(1'b1, 1'b1, 1'b0, 16'd5, 36'd0, 1'b0, 1'b0, 16'd0, 36'd0);
    chk("entry_gnt_e3", 64'(cpu_gnt), 64'd1);
    chk("entry_stall", 64'(cpu_stall), 64'd0);
    push(1'b0, 36'h123456789);
    step(1'b1, 1'b0, 1'b0, 16'd0, 36'd0, 1'b0, 1'b0, 16'd0, 36'd0);

    // Contention with MAXBURST=4: C,C,C,C,I repeating.
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, 1'b0, 16'd1, 36'd0, 1'b1, 1'b0, 16'd2, 36'd0);
      exp_io = (k % 5 == 4);
      chk("cont_cpu_gnt", 64'(cpu_gnt), 64'(!exp_io));
      chk("cont_io_gnt", 64'(io_gnt), 64'(exp_io));
      chk("cont_stall", 64'(cpu_stall), 64'(exp_io));
      chk("cont_mem_addr", 64'(mem_addr), exp_io ? 64'd2 : 64'd1);
      push(exp_io, exp_io ? 36'hB : 36'hA);
    end

    // Alternating single-port reads, back to back.
    for (int k = 0; k < 4; k++) begin
      exp_io = k[0];
      step(1'b1, !exp_io, 1'b0, 16'd1, 36'd0, exp_io, 1'b0, 16'd2, 36'd0);
      chk("alt_gnt", {62'd0, cpu_gnt, io_gnt}, exp_io ? 64'd1 : 64'd2);
      push(exp_io, exp_io ? 36'hB : 36'hA);
    end
    step(1'b1, 1'b0, 1'b0, 16'd0, 36'd0, 1'b0, 1'b0, 16'd0, 36'd0);

    // Switch off with a CPU read in flight: DRAIN still returns it.
    step(1'b0, 1'b0, 1'b0, 16'd0, 36'd0, 1'b0, 1'b0, 16'd0, 36'd0);
    step(1'b0, 1'b1, 1'b0, 16'd1, 36'd0, 1'b0, 1'b0, 16'd0, 36'd0);
    chk("off_cpu_gnt", 64'(cpu_gnt), 64'd1);
    push(1'b0, 36'hA);
    step(1'b0, 1'b1, 1'b0, 16'd1, 36'd0, 1'b0, 1'b0, 16'd0, 36'd0);
    chk("drain_gnt", 64'(cpu_gnt), 64'd0);
    chk("drain_stall", 64'(cpu_stall), 64'd1);
    chk("drain_rvalid", 64'(cpu_rvalid), 64'd1);
    step(1'b0, 1'b1, 1'b0, 16'd1, 36'd0, 1'b0, 1'b0, 16'd0, 36'd0);
    chk("halt2_gnt", 64'(cpu_gnt), 64'd0);
    chk("halt2_stall", 64'(cpu_stall), 64'd1);

    // Async reset with an I/O read outstanding: no return afterwards.
    step(1'b0, 1'b0, 1'b0, 16'd0, 36'd0, 1'b1, 1'b0, 16'd2, 36'd0);
    chk("ar_io_gnt", 64'(io_gnt), 64'd1);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("ar_io_rvalid", 64'(io_rvalid), 64'd0);
    chk("ar_io_gnt0", 64'(io_gnt), 64'd0);
    chk("ar_mem_en", 64'(mem_en), 64'd0);
    chk("ar_mem_addr", 64'(mem_addr), 64'd0);
    chk("ar_rdata", {28'd0, cpu_rdata} | {28'd0, io_rdata}, 64'd0);
    chk("ar_stall", 64'(cpu_stall), 64'd1);
    io_req = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'd0, 36'd0, 1'b0, 1'b0, 16'd0, 36'd0);
      chk("post_rst_io_rvalid", 64'(io_rvalid), 64'd0);
    end
    step(1'b0, 1'b0, 1'b0, 16'd0, 36'd0, 1'b1, 1'b0, 16'd2, 36'd0);
    chk("post_rst_io_gnt", 64'(io_gnt), 64'd1);
    push(1'b1, 36'hB);
    step(1'b0, 1'b0, 1'b0, 16'd0, 36'd0, 1'b0, 1'b0, 16'd0, 36'd0);
    step(1'b0, 1'b0, 1'b0, 16'd0, 36'd0, 1'b0, 1'b0, 16'd0, 36'd0);

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
